instr_encoder: RTL and testbench

- Write-side counterpart of the main control decoder: takes symbolic instructions (operation index plus fields) over a valid/ready handshake.
- Encodes each into a 32-bit MIPS word using the opcode set the control decoder recognises.
- Writes the words sequentially into instruction memory.
- Used for self-loading test programs and the bring-up loader in front of the datapath's instruction memory.

---
 rtl/instr_encoder.sv | 211 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: write-side companion of the control decoder.
// Accepts symbolic instructions over valid/ready and encodes each one into a
// 32-bit MIPS word. The words are written one after another into
// instruction memory, so a test program or the bring-up loader can fill the
// memory in front of the datapath.
module instr_encoder #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        op_sel,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm,
   input  logic [25:0]       target,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   // Opcodes understood by the control decoder
   localparam logic [5:0] OP_RTYPE   = 6'b000000;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_BITSWAP = 6'b011111;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_SLTIU   = 6'b001011;
   localparam logic [5:0] OP_B       = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BGEZ    = 6'b000001;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_J       = 6'b000010;

   // Fill limit and the last address the pointer may reach
   localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR_C = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      ENC,
      WR
   } stateT;

   stateT state;
   stateT stateNext;

   logic        accept;
   logic [4:0]  opSelQ;
   logic [4:0]  rsQ;
   logic [4:0]  rtQ;
   logic [4:0]  rdQ;
   logic [4:0]  shamtQ;
   logic [5:0]  functQ;
   logic [15:0] immQ;
   logic [25:0] targetQ;

   logic        encLegal;
   logic [31:0] encWord;
   logic [ADDR_W:0] countInc;

   assign countInc = count + 1'b1;
   assign full     = (count == DEPTH_C);

   // in_ready is forced low while reset is held, otherwise IDLE and not full
   assign in_ready = rst_n && (state == IDLE) && !full;

   // clear always wins, so a transfer is only taken when clear is low
   assign accept = in_valid && in_ready && !clear;

   // The write strobe is combinational so clear can kill it in the same cycle
   assign mem_we = (state == WR) && !clear;

   // Encode the captured fields; forced fields replace the unused inputs
   always_comb begin
      encLegal = 1'b1;
      encWord  = 32'h0000_0000;
      case (opSelQ)
         5'd0:  encWord = {OP_RTYPE, rsQ, rtQ, rdQ, shamtQ, functQ};
         5'd1:  encWord = {OP_LUI, 5'd0, rtQ, immQ};
         5'd2:  encWord = {OP_BITSWAP, rsQ, rtQ, rdQ, shamtQ, functQ};
         5'd3:  encWord = {OP_LW, rsQ, rtQ, immQ};
         5'd4:  encWord = {OP_ADDI, rsQ, rtQ, immQ};
         5'd5:  encWord = {OP_ADDIU, rsQ, rtQ, immQ};
         5'd6:  encWord = {OP_SW, rsQ, rtQ, immQ};
         5'd7:  encWord = {OP_ANDI, rsQ, rtQ, immQ};
         5'd8:  encWord = {OP_ORI, rsQ, rtQ, immQ};
         5'd9:  encWord = {OP_XORI, rsQ, rtQ, immQ};
         5'd10: encWord = {OP_SLTI, rsQ, rtQ, immQ};
         5'd11: encWord = {OP_SLTIU, rsQ, rtQ, immQ};
         5'd12: encWord = {OP_B, 5'd0, 5'd0, immQ};
         5'd13: encWord = {OP_BEQ, rsQ, rtQ, immQ};
         5'd14: encWord = {OP_BGEZ, rsQ, 5'd1, immQ};
         5'd15: encWord = {OP_BNE, rsQ, rtQ, immQ};
         5'd16: encWord = {OP_J, targetQ};
         default: begin
            encLegal = 1'b0;
            encWord  = 32'h0000_0000;
         end
      endcase
   end

   // Next-state logic for the accept / encode / write sequence
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (accept) begin
               stateNext = ENC;
            end
         end
         ENC: begin
            stateNext = encLegal ? WR : IDLE;
         end
         WR: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      if (clear) begin
         stateNext = IDLE;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Capture all instruction fields at the moment of acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opSelQ  <= '0;
         rsQ     <= '0;
         rtQ     <= '0;
         rdQ     <= '0;
         shamtQ  <= '0;
         functQ  <= '0;
         immQ    <= '0;
         targetQ <= '0;
      end else if (accept) begin
         opSelQ  <= op_sel;
         rsQ     <= rs;
         rtQ     <= rt;
         rdQ     <= rd;
         shamtQ  <= shamt;
         functQ  <= funct;
         immQ    <= imm;
         targetQ <= target;
      end
   end

   // Load the write data during ENC for legal operations; it holds afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_wdata <= 32'h0000_0000;
      end else if (!clear && (state == ENC) && encLegal) begin
         mem_wdata <= encWord;
      end
   end

   // Sticky error flag for illegal operation indices
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (clear) begin
         err <= 1'b0;
      end else if ((state == ENC) && !encLegal) begin
         err <= 1'b1;
      end
   end

   // Advance the write pointer and word count after each completed write;
   // the pointer parks on the last address instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         mem_addr <= '0;
      end else if (clear) begin
         count    <= '0;
         mem_addr <= '0;
      end else if (state == WR) begin
         count <= countInc;
         if ((countInc < DEPTH_C) && (mem_addr != LAST_ADDR_C)) begin
            mem_addr <= mem_addr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against
// a table-driven reference encoder and a simple fill-level model.
module tb_instr_encoder;

   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;

   // Opcode for each legal operation index, straight from the opcode list
   localparam int OP_TAB [17] = '{
      'h00, 'h0F, 'h1F, 'h23, 'h08, 'h09, 'h2B, 'h0C, 'h0D,
      'h0E, 'h0A, 'h0B, 'h03, 'h04, 'h01, 'h05, 'h02
   };

   logic              clk;
   logic              rst_n;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        op_sel;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       target;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;

   int checks = 0;
   int errors = 0;

   int   expCount;
   int   expAddr;
   logic expErr;

   instr_encoder #(
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op_sel   (op_sel),
      .rs       (rs),
      .rt       (rt),
      .rd       (rd),
      .shamt    (shamt),
      .funct    (funct),
      .imm      (imm),
      .target   (target),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .count    (count),
      .full     (full),
      .err      (err)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference encoder: picks the format from the operation class
   function automatic logic [31:0] refEncode(input int op, input int rsV, input int rtV,
                                             input int rdV, input int shV, input int fnV,
                                             input int immV, input int tgV);
      logic [31:0] opc;
      logic [31:0] r1;
      logic [31:0] r2;
      if (op > 16) return 32'h0;
      opc = 32'(OP_TAB[op]);
      if (op == 0 || op == 2)
         return (opc << 26) | (32'(rsV) << 21) | (32'(rtV) << 16) | (32'(rdV) << 11)
              | (32'(shV) << 6) | 32'(fnV);
      if (op == 16)
         return (opc << 26) | 32'(tgV);
      r1 = 32'(rsV);
      r2 = 32'(rtV);
      if (op == 1)  r1 = 0;
      if (op == 12) begin r1 = 0; r2 = 0; end
      if (op == 14) r2 = 1;
      return (opc << 26) | (r1 << 21) | (r2 << 16) | 32'(immV);
   endfunction

   // One comparison point
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Synchronous clear pulse; the model restarts as well
   task automatic doClear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      expCount = 0;
      expAddr  = 0;
      expErr   = 1'b0;
   endtask

   // Wait (bounded) for in_ready
   task automatic waitReady();
      int waited = 0;
      while (!in_ready && waited < 10) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) checkOutput("readyTimeout", 32'(in_ready), 32'd1);
   endtask

   task automatic driveFields(input int op, input int rsV, input int rtV, input int rdV,
                              input int shV, input int fnV, input int immV, input int tgV);
      op_sel = 5'(op);
      rs     = 5'(rsV);
      rt     = 5'(rtV);
      rd     = 5'(rdV);
      shamt  = 5'(shV);
      funct  = 6'(fnV);
      imm    = 16'(immV);
      target = 26'(tgV);
   endtask

   // Send one instruction and follow it through encode and write
   task automatic applyStimulus(input int op, input int rsV, input int rtV, input int rdV,
                                input int shV, input int fnV, input int immV, input int tgV,
                                input logic [31:0] expWord);
      bit legal;
      legal = (op < 17);
      waitReady();
      driveFields(op, rsV, rtV, rdV, shV, fnV, immV, tgV);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("encNoWe", 32'(mem_we), 32'd0);
      checkOutput("encNotReady", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      if (legal) begin
         checkOutput("wrWe", 32'(mem_we), 32'd1);
         checkOutput("wrAddr", 32'(mem_addr), 32'(expAddr));
         checkOutput("wrData", mem_wdata, expWord);
         checkOutput("wrNotReady", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         expCount++;
         expAddr = (expCount < DEPTH) ? expCount : DEPTH - 1;
         checkOutput("postWe", 32'(mem_we), 32'd0);
         checkOutput("postCount", 32'(count), 32'(expCount));
         checkOutput("postFull", 32'(full), 32'(expCount == DEPTH));
         checkOutput("postAddr", 32'(mem_addr), 32'(expAddr));
         checkOutput("postDataHold", mem_wdata, expWord);
         checkOutput("postErr", 32'(err), 32'(expErr));
      end else begin
         expErr = 1'b1;
         checkOutput("illNoWe", 32'(mem_we), 32'd0);
         checkOutput("illErr", 32'(err), 32'd1);
         checkOutput("illCount", 32'(count), 32'(expCount));
         checkOutput("illAddr", 32'(mem_addr), 32'(expAddr));
      end
   endtask

   // Present an illegal op while full: must be ignored entirely
   task automatic fullProbe();
      driveFields(20, 1, 2, 3, 4, 5, 6, 7);
      in_valid = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         checkOutput("fullNoWe", 32'(mem_we), 32'd0);
         checkOutput("fullNotReady", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      checkOutput("fullErrHold", 32'(err), 32'(expErr));
      checkOutput("fullCount", 32'(count), 32'(expCount));
   endtask

   // Accept one instruction by hand and stop in ENC
   task automatic acceptOnly(input int op);
      waitReady();
      driveFields(op, 1, 2, 3, 0, 0, 9, 0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Directed sequence followed by randomized traffic
   initial begin
      int nWrites;
      int op;
      int f [8];

      rst_n    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      driveFields(0, 0, 0, 0, 0, 0, 0, 0);
      expCount = 0;
      expAddr  = 0;
      expErr   = 1'b0;

      #3;
      checkOutput("rstReady", 32'(in_ready), 32'd0);
      checkOutput("rstWe", 32'(mem_we), 32'd0);
      checkOutput("rstAddr", 32'(mem_addr), 32'd0);
      checkOutput("rstData", mem_wdata, 32'd0);
      checkOutput("rstCount", 32'(count), 32'd0);
      checkOutput("rstFull", 32'(full), 32'd0);
      checkOutput("rstErr", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("relReady", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Test-plan words with literal expectations
      applyStimulus(4, 0, 8, 0, 0, 0, 'h0005, 0, 32'h2008_0005);
      applyStimulus(0, 8, 9, 10, 0, 'h20, 0, 0, 32'h0109_5020);
      applyStimulus(3, 8, 9, 0, 0, 0, 4, 0, 32'h8D09_0004);
      applyStimulus(20, 1, 1, 1, 1, 1, 1, 1, 32'h0);
      applyStimulus(1, 5, 8, 0, 0, 0, 'h1234, 0, 32'h3C08_1234);
      checkOutput("fillFull", 32'(full), 32'd1);
      checkOutput("fillReady", 32'(in_ready), 32'd0);
      fullProbe();

      doClear();
      checkOutput("clrCount", 32'(count), 32'd0);
      checkOutput("clrFull", 32'(full), 32'd0);
      checkOutput("clrErr", 32'(err), 32'd0);
      checkOutput("clrAddr", 32'(mem_addr), 32'd0);
      checkOutput("clrReady", 32'(in_ready), 32'd1);
      applyStimulus(14, 8, 7, 0, 0, 0, 3, 0, 32'h0501_0003);
      applyStimulus(16, 0, 0, 0, 0, 0, 0, 'h10, 32'h0800_0010);

      // Hold in_valid: exactly DEPTH writes at consecutive addresses
      doClear();
      driveFields(4, 0, 8, 0, 0, 0, 5, 0);
      in_valid = 1'b1;
      nWrites = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (mem_we) begin
            checkOutput("holdAddr", 32'(mem_addr), 32'(nWrites));
            checkOutput("holdData", mem_wdata, 32'h2008_0005);
            nWrites++;
         end
      end
      in_valid = 1'b0;
      checkOutput("holdWrites", 32'(nWrites), 32'(DEPTH));
      checkOutput("holdFull", 32'(full), 32'd1);
      checkOutput("holdReady", 32'(in_ready), 32'd0);
      checkOutput("holdAddrPark", 32'(mem_addr), 32'(DEPTH - 1));
      expCount = DEPTH;
      expAddr  = DEPTH - 1;
      doClear();
      applyStimulus(8, 3, 4, 0, 0, 0, 'hBEEF, 0, 32'h3464_BEEF);

      // clear during WR kills the strobe in that cycle
      acceptOnly(5);
      @(posedge clk); #1;
      checkOutput("preClrWe", 32'(mem_we), 32'd1);
      clear = 1'b1;
      #1;
      checkOutput("clrWrWe", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      clear = 1'b0;
      expCount = 0;
      expAddr  = 0;
      expErr   = 1'b0;
      checkOutput("clrWrCount", 32'(count), 32'd0);
      checkOutput("clrWrNoWe", 32'(mem_we), 32'd0);
      checkOutput("clrWrReady", 32'(in_ready), 32'd1);

      // clear together with in_valid in IDLE: nothing accepted
      driveFields(4, 1, 2, 0, 0, 0, 7, 0);
      clear    = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      checkOutput("clrAccReady", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      checkOutput("clrAccNoWe", 32'(mem_we), 32'd0);
      checkOutput("clrAccCount", 32'(count), 32'd0);

      // Asynchronous reset while in ENC
      applyStimulus(7, 2, 3, 0, 0, 0, 'h00FF, 0, 32'h3043_00FF);
      acceptOnly(6);
      rst_n = 1'b0;
      #1;
      checkOutput("arstWe", 32'(mem_we), 32'd0);
      checkOutput("arstCount", 32'(count), 32'd0);
      checkOutput("arstAddr", 32'(mem_addr), 32'd0);
      checkOutput("arstData", mem_wdata, 32'd0);
      checkOutput("arstReady", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         checkOutput("arstNoWe", 32'(mem_we), 32'd0);
      end
      checkOutput("arstCountAfter", 32'(count), 32'd0);
      expCount = 0;
      expAddr  = 0;
      expErr   = 1'b0;

      // Randomized traffic against the reference model
      for (int n = 0; n < 40; n++) begin
         if (expCount == DEPTH) begin
            checkOutput("rndFullReady", 32'(in_ready), 32'd0);
            fullProbe();
            doClear();
         end
         if ($urandom_range(0, 7) == 0) doClear();
         op   = int'($urandom_range(0, 22));
         f[0] = int'($urandom_range(0, 31));
         f[1] = int'($urandom_range(0, 31));
         f[2] = int'($urandom_range(0, 31));
         f[3] = int'($urandom_range(0, 31));
         f[4] = int'($urandom_range(0, 63));
         f[5] = int'($urandom_range(0, 65535));
         f[6] = int'($urandom_range(0, 32'h03FF_FFFF));
         applyStimulus(op, f[0], f[1], f[2], f[3], f[4], f[5], f[6],
                       refEncode(op, f[0], f[1], f[2], f[3], f[4], f[5], f[6]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
